// File: rtl/regread.sv
// Operand-read stage: GPR/FPR banks, write-back port with same-cycle bypass,
// and a per-register busy scoreboard that stalls reads until producers retire.
module regread #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            enable,
    output logic            done,
    input  logic [REGW-1:0] rs1,
    input  logic            rs1_sel,
    input  logic [REGW-1:0] rs2,
    input  logic            rs2_sel,
    input  logic [REGW-1:0] rd,
    input  logic [1:0]      rd_sel,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wgenable,
    input  logic [REGW-1:0] wgreg,
    input  logic [XLEN-1:0] wgdata,
    input  logic            wfenable,
    input  logic [REGW-1:0] wfreg,
    input  logic [XLEN-1:0] wfdata
);
    localparam int NREG = 1 << REGW;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    function automatic logic [NREG-1:0] onehot(input logic [REGW-1:0] idx);
        onehot = {{(NREG-1){1'b0}}, 1'b1} << idx;
    endfunction

    logic [XLEN-1:0] r_gpr [NREG];
    logic [XLEN-1:0] r_fpr [NREG];
    logic [NREG-1:0] r_busy_g;
    logic [NREG-1:0] r_busy_f;
    state_t          r_state;
    state_t          w_state_next;
    logic [REGW-1:0] r_rs1, r_rs2, r_rd;
    logic            r_rs1_sel, r_rs2_sel;
    logic [1:0]      r_rd_sel;
    logic            r_done;
    logic [XLEN-1:0] r_rs1_data, r_rs2_data;

    logic [REGW-1:0] w_src [2];
    logic            w_src_sel [2];
    logic            w_ready [2];
    logic [XLEN-1:0] w_op [2];
    logic [REGW-1:0] w_rd;
    logic [1:0]      w_rd_sel;
    logic            w_issue;
    logic [NREG-1:0] w_clr_g, w_clr_f, w_set_g, w_set_f;

    // In IDLE the request is evaluated straight from the ports; in WAIT from the captured copy.
    always_comb begin
        w_src[0]     = (r_state == ST_IDLE) ? rs1     : r_rs1;
        w_src[1]     = (r_state == ST_IDLE) ? rs2     : r_rs2;
        w_src_sel[0] = (r_state == ST_IDLE) ? rs1_sel : r_rs1_sel;
        w_src_sel[1] = (r_state == ST_IDLE) ? rs2_sel : r_rs2_sel;
        w_rd         = (r_state == ST_IDLE) ? rd      : r_rd;
        w_rd_sel     = (r_state == ST_IDLE) ? rd_sel  : r_rd_sel;
    end

    // Per-source readiness and bypassed operand value.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_ready[i] = 1'b0;
            w_op[i]    = '0;
            if (!w_src_sel[i]) begin
                if (w_src[i] == '0) begin
                    w_ready[i] = 1'b1;
                    w_op[i]    = '0;
                end else if (wgenable && (wgreg == w_src[i])) begin
                    w_ready[i] = 1'b1;
                    w_op[i]    = wgdata;
                end else begin
                    w_ready[i] = ~r_busy_g[w_src[i]];
                    w_op[i]    = r_gpr[w_src[i]];
                end
            end else begin
                if (wfenable && (wfreg == w_src[i])) begin
                    w_ready[i] = 1'b1;
                    w_op[i]    = wfdata;
                end else begin
                    w_ready[i] = ~r_busy_f[w_src[i]];
                    w_op[i]    = r_fpr[w_src[i]];
                end
            end
        end
    end

    // Next-state and issue decision.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_ready[0] && w_ready[1]) begin
                    w_issue      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (enable) begin
                    w_state_next = ST_WAIT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_ready[0] && w_ready[1]) begin
                    w_issue      = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            default: begin
                w_issue      = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Scoreboard masks; set is OR'd after clear so a new producer wins over a retiring one.
    always_comb begin
        w_clr_g = (wgenable && (wgreg != '0)) ? onehot(wgreg) : '0;
        w_clr_f = wfenable ? onehot(wfreg) : '0;
        w_set_g = (w_issue && (w_rd_sel == 2'b10) && (w_rd != '0)) ? onehot(w_rd) : '0;
        w_set_f = (w_issue && (w_rd_sel == 2'b11)) ? onehot(w_rd) : '0;
    end

    // Register banks; x0 is hardwired and never written.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                r_gpr[i] <= '0;
                r_fpr[i] <= '0;
            end
        end else begin
            if (wgenable && (wgreg != '0)) r_gpr[wgreg] <= wgdata;
            if (wfenable) r_fpr[wfreg] <= wfdata;
        end
    end

    // State, captured request, scoreboard and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_rs1_sel  <= 1'b0;
            r_rs2_sel  <= 1'b0;
            r_rd_sel   <= 2'b00;
            r_busy_g   <= '0;
            r_busy_f   <= '0;
            r_done     <= 1'b0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else begin
            r_state  <= w_state_next;
            r_busy_g <= (r_busy_g & ~w_clr_g) | w_set_g;
            r_busy_f <= (r_busy_f & ~w_clr_f) | w_set_f;
            r_done   <= w_issue;
            if ((r_state == ST_IDLE) && enable) begin
                r_rs1     <= rs1;
                r_rs2     <= rs2;
                r_rd      <= rd;
                r_rs1_sel <= rs1_sel;
                r_rs2_sel <= rs2_sel;
                r_rd_sel  <= rd_sel;
            end
            if (w_issue) begin
                r_rs1_data <= w_op[0];
                r_rs2_data <= w_op[1];
            end
        end
    end

    assign done     = r_done;
    assign rs1_data = r_rs1_data;
    assign rs2_data = r_rs2_data;
endmodule
